ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the 5-stage pipeline. It sits between the ID/EX pipeline register and the EX/MEM register. It applies operand forwarding, runs the single-cycle ALU and the RV32M multiply ops, and runs DIV/DIVU/REM/REMU on a 32-iteration sequential divider that stalls the front of the pipe. It also resolves branches and jumps and drives the fetch redirect.

## Interface
Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- DIV_CYCLES, 32, number of divider iterations; equals XLEN.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- valid_e  in  1  the ID/EX slot holds a live instruction.
- rd1_e, rd2_e  in  32  register operands from ID/EX.
- imm_e  in  32  immediate.
- pc4_e  in  32  PC+4 of the instruction. PC is derived as pc4_e−4.
- instr_e  in  32  raw instruction. Bits [14:12] give the branch funct3.
- alu_op  in  5  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB, 11 AUIPC, 12 MUL, 13 MULH, 14 MULHSU, 15 MULHU, 16 DIV, 17 DIVU, 18 REM, 19 REMU. Codes 20–31 produce 0.
- alu_src  in  1  1: operand B is imm_e.
- is_branch, is_jal, is_jalr  in  1  control-transfer class.
- fwd_a_sel, fwd_b_sel  in  2  forwarding select. 00 selects the register operand, 01 fwd_mem, 10 fwd_wb, 11 the register operand.
- fwd_mem, fwd_wb  in  32  forwarded values.
- result_e  out  32  ALU/mul/div result, or pc4_e for jumps.
- store_data_e  out  32  forwarded operand B, taken before the alu_src mux.
- redirect  out  1  taken branch or jump.
- redirect_pc  out  32  target address.
- ex_stall  out  1  hold IF, ID and the ID/EX register.
- ex_valid  out  1  result_e is final this cycle; EX/MEM captures a bubble otherwise.

## Operation
- Operand A is the forwarded rd1_e. Operand B is imm_e when alu_src=1, otherwise the forwarded rd2_e.
- Shift amount is B[4:0].
- MULH, MULHSU and MULHU return bits [63:32] of the signed×signed, signed×unsigned and unsigned×unsigned 64-bit product respectively.
- Branch funct3 and condition:
  - 000 BEQ, 001 BNE: equality of A and forwarded rd2_e.
  - 100 BLT, 101 BGE: signed comparison.
  - 110 BLTU, 111 BGEU: unsigned comparison.
  - Other funct3 values never take.
  - The comparison always uses forwarded rd2_e, regardless of alu_src.
- Targets:
  - Branch and JAL: (pc4_e−4)+imm_e.
  - JALR: (A+imm_e) with bit 0 cleared.
  - Jumps return result_e=pc4_e.
- redirect = valid_e & ex_valid & (is_jal | is_jalr | (is_branch & cond)).

Divider FSM (IDLE, RUN, DONE), counter 0..31:
- IDLE, valid_e and alu_op in 16–19:
  - latch A, B, the op, and the operand signs;
  - ex_stall=1, ex_valid=0;
  - go to RUN with count=0.
- RUN: one restoring shift-subtract step on the magnitudes per cycle; ex_stall=1, ex_valid=0. At count=31, go to DONE.
- DONE: ex_stall=0, ex_valid=1, result driven from the divider registers with sign fix-up; next state IDLE.
- Divide by zero: quotient 0xFFFFFFFF, remainder equals the dividend, for both signed and unsigned ops.
- Signed overflow (0x80000000 / −1): quotient 0x80000000, remainder 0.
- Special cases take the same latency as normal divides.
- Operands are latched in IDLE only. Forwarding-input changes during RUN and DONE have no effect.
- All other ops: ex_stall=0 and ex_valid=valid_e.

## Timing
- All non-divide ops are combinational: zero latency, result in the same cycle.
- Divide: accept cycle, then 32 RUN cycles, then the DONE cycle.
  - ex_stall is high for 33 consecutive cycles.
  - The instruction occupies EX for 34 cycles.
  - ex_valid is high in the DONE cycle only.
- ex_stall is a combinational output and is not registered.
- The instruction after a divide enters EX on the cycle after DONE. A back-to-back divide therefore starts from IDLE, with no idle gap.
- valid_e=0 in IDLE: no state change, redirect=0, ex_valid=0.
- Synchronous reset:
  - state IDLE, count 0, divider registers 0, ex_stall=0, ex_valid=0, redirect=0;
  - an in-flight divide is abandoned with no result;
  - on the cycle after reset deasserts, a divide can be accepted.

## Test plan
- ADD with fwd_a_sel=01, fwd_mem=5, rd2_e=7 → result_e=12, ex_valid=1, ex_stall=0.
- BLT with A=0xFFFFFFFF, B=1, pc4_e=0x104, imm_e=0x20 → redirect=1, redirect_pc=0x120. BLTU with the same operands → redirect=0.
- JALR with A=0x1001, imm_e=2, pc4_e=0x50 → redirect_pc=0x1002, result_e=0x50.
- DIV −7/2 → ex_stall high for 33 cycles, then result_e=0xFFFFFFFD. REM −7/2 → 0xFFFFFFFF.
- DIVU 9/0 → 0xFFFFFFFF. REM 9/0 → 9. DIV 0x80000000/0xFFFFFFFF → 0x80000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- Reset asserted at RUN count=10 → next cycle ex_stall=0 and state IDLE. A following DIVU 100/7 → 14 after the full 34-cycle occupancy.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, single-cycle ALU and RV32M multiply, branch/jump
// resolution, and a sequential restoring divider that stalls the front of the pipe.
module ex_stage #(
  parameter int XLEN       = 32,
  parameter int DIV_CYCLES = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_e,
  input  logic [XLEN-1:0] rd1_e,
  input  logic [XLEN-1:0] rd2_e,
  input  logic [XLEN-1:0] imm_e,
  input  logic [XLEN-1:0] pc4_e,
  input  logic [31:0]     instr_e,
  input  logic [4:0]      alu_op,
  input  logic            alu_src,
  input  logic            is_branch,
  input  logic            is_jal,
  input  logic            is_jalr,
  input  logic [1:0]      fwd_a_sel,
  input  logic [1:0]      fwd_b_sel,
  input  logic [XLEN-1:0] fwd_mem,
  input  logic [XLEN-1:0] fwd_wb,
  output logic [XLEN-1:0] result_e,
  output logic [XLEN-1:0] store_data_e,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            ex_stall,
  output logic            ex_valid
);

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_SLL    = 5'd2;
  localparam logic [4:0] OP_SLT    = 5'd3;
  localparam logic [4:0] OP_SLTU   = 5'd4;
  localparam logic [4:0] OP_XOR    = 5'd5;
  localparam logic [4:0] OP_SRL    = 5'd6;
  localparam logic [4:0] OP_SRA    = 5'd7;
  localparam logic [4:0] OP_OR     = 5'd8;
  localparam logic [4:0] OP_AND    = 5'd9;
  localparam logic [4:0] OP_PASSB  = 5'd10;
  localparam logic [4:0] OP_AUIPC  = 5'd11;
  localparam logic [4:0] OP_MUL    = 5'd12;
  localparam logic [4:0] OP_MULH   = 5'd13;
  localparam logic [4:0] OP_MULHSU = 5'd14;
  localparam logic [4:0] OP_MULHU  = 5'd15;
  localparam logic [4:0] OP_DIV    = 5'd16;
  localparam logic [4:0] OP_REMU   = 5'd19;

  localparam int CW = $clog2(DIV_CYCLES);
  localparam int PW = 2 * XLEN + 2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} div_state_t;

  // ---------------- operand forwarding ----------------
  logic [XLEN-1:0] reg_op [2];
  logic [1:0]      fwd_sel [2];
  logic [XLEN-1:0] fwd_op [2];

  assign reg_op[0]  = rd1_e;
  assign reg_op[1]  = rd2_e;
  assign fwd_sel[0] = fwd_a_sel;
  assign fwd_sel[1] = fwd_b_sel;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      assign fwd_op[gi] = (fwd_sel[gi] == 2'b01) ? fwd_mem :
                          (fwd_sel[gi] == 2'b10) ? fwd_wb  : reg_op[gi];
    end
  endgenerate

  logic [XLEN-1:0] op_a, rs2_fwd, op_b, pc_e;

  assign op_a         = fwd_op[0];
  assign rs2_fwd      = fwd_op[1];
  assign op_b         = alu_src ? imm_e : rs2_fwd;
  assign store_data_e = rs2_fwd;
  assign pc_e         = pc4_e - XLEN'(4);

  // ---------------- multiplier ----------------
  // One signed multiplier serves all four ops; operands are extended per-op signedness.
  logic            mul_a_sgn, mul_b_sgn;
  logic signed [PW-1:0] mul_a, mul_b, mul_p;

  assign mul_a_sgn = (alu_op == OP_MULH) || (alu_op == OP_MULHSU);
  assign mul_b_sgn = (alu_op == OP_MULH);
  assign mul_a     = {{(XLEN+2){mul_a_sgn & op_a[XLEN-1]}}, op_a};
  assign mul_b     = {{(XLEN+2){mul_b_sgn & op_b[XLEN-1]}}, op_b};
  assign mul_p     = mul_a * mul_b;

  // ---------------- ALU ----------------
  logic [XLEN-1:0] alu_result;

  always_comb begin
    alu_result = '0;
    case (alu_op)
      OP_ADD:    alu_result = op_a + op_b;
      OP_SUB:    alu_result = op_a - op_b;
      OP_SLL:    alu_result = op_a << op_b[4:0];
      OP_SLT:    alu_result = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      OP_SLTU:   alu_result = {{(XLEN-1){1'b0}}, op_a < op_b};
      OP_XOR:    alu_result = op_a ^ op_b;
      OP_SRL:    alu_result = op_a >> op_b[4:0];
      OP_SRA:    alu_result = $signed(op_a) >>> op_b[4:0];
      OP_OR:     alu_result = op_a | op_b;
      OP_AND:    alu_result = op_a & op_b;
      OP_PASSB:  alu_result = op_b;
      OP_AUIPC:  alu_result = pc_e + imm_e;
      OP_MUL:    alu_result = mul_p[XLEN-1:0];
      OP_MULH,
      OP_MULHSU,
      OP_MULHU:  alu_result = mul_p[2*XLEN-1:XLEN];
      default:   alu_result = '0;
    endcase
  end

  // ---------------- branch resolution ----------------
  logic br_cond;

  always_comb begin
    br_cond = 1'b0;
    case (instr_e[14:12])
      3'b000:  br_cond = (op_a == rs2_fwd);
      3'b001:  br_cond = (op_a != rs2_fwd);
      3'b100:  br_cond = ($signed(op_a) <  $signed(rs2_fwd));
      3'b101:  br_cond = ($signed(op_a) >= $signed(rs2_fwd));
      3'b110:  br_cond = (op_a <  rs2_fwd);
      3'b111:  br_cond = (op_a >= rs2_fwd);
      default: br_cond = 1'b0;
    endcase
  end

  // ---------------- divider ----------------
  div_state_t      state_reg, state_next;
  logic [CW-1:0]   count_reg, count_next;
  logic [XLEN-1:0] quo_reg, quo_next;
  logic [XLEN-1:0] rem_reg, rem_next;
  logic [XLEN-1:0] dvs_reg, dvs_next;
  logic [XLEN-1:0] dvd_reg, dvd_next;
  logic            div_zero_reg, div_zero_next;
  logic            rem_sel_reg, rem_sel_next;
  logic            neg_q_reg, neg_q_next;
  logic            neg_r_reg, neg_r_next;

  logic            is_div_op, div_signed;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   r_shift, r_diff;
  logic            stall_raw, valid_raw;

  assign is_div_op  = valid_e && (alu_op >= OP_DIV) && (alu_op <= OP_REMU);
  // DIV and REM have even codes; DIVU and REMU odd.
  assign div_signed = ~alu_op[0];
  assign a_mag      = (div_signed & op_a[XLEN-1]) ? -op_a : op_a;
  assign b_mag      = (div_signed & op_b[XLEN-1]) ? -op_b : op_b;
  assign r_shift    = {rem_reg, quo_reg[XLEN-1]};
  assign r_diff     = r_shift - {1'b0, dvs_reg};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      count_reg    <= '0;
      quo_reg      <= '0;
      rem_reg      <= '0;
      dvs_reg      <= '0;
      dvd_reg      <= '0;
      div_zero_reg <= 1'b0;
      rem_sel_reg  <= 1'b0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      quo_reg      <= quo_next;
      rem_reg      <= rem_next;
      dvs_reg      <= dvs_next;
      dvd_reg      <= dvd_next;
      div_zero_reg <= div_zero_next;
      rem_sel_reg  <= rem_sel_next;
      neg_q_reg    <= neg_q_next;
      neg_r_reg    <= neg_r_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    quo_next      = quo_reg;
    rem_next      = rem_reg;
    dvs_next      = dvs_reg;
    dvd_next      = dvd_reg;
    div_zero_next = div_zero_reg;
    rem_sel_next  = rem_sel_reg;
    neg_q_next    = neg_q_reg;
    neg_r_next    = neg_r_reg;
    stall_raw     = 1'b0;
    valid_raw     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        valid_raw = valid_e & ~is_div_op;
        if (is_div_op) begin
          stall_raw     = 1'b1;
          state_next    = S_RUN;
          count_next    = '0;
          quo_next      = a_mag;
          rem_next      = '0;
          dvs_next      = b_mag;
          dvd_next      = op_a;
          div_zero_next = (op_b == '0);
          rem_sel_next  = alu_op[1];
          neg_q_next    = div_signed & (op_a[XLEN-1] ^ op_b[XLEN-1]);
          neg_r_next    = div_signed & op_a[XLEN-1];
        end
      end
      S_RUN: begin
        stall_raw = 1'b1;
        if (!r_diff[XLEN]) begin
          rem_next = r_diff[XLEN-1:0];
          quo_next = {quo_reg[XLEN-2:0], 1'b1};
        end else begin
          rem_next = r_shift[XLEN-1:0];
          quo_next = {quo_reg[XLEN-2:0], 1'b0};
        end
        count_next = count_reg + 1'b1;
        if (count_reg == CW'(DIV_CYCLES - 1)) begin
          state_next = S_DONE;
          count_next = '0;
        end
      end
      S_DONE: begin
        valid_raw  = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Sign fix-up; divide-by-zero bypasses the magnitude result entirely.
  logic [XLEN-1:0] q_fix, r_fix, div_result;

  assign q_fix      = div_zero_reg ? '1      : (neg_q_reg ? -quo_reg : quo_reg);
  assign r_fix      = div_zero_reg ? dvd_reg : (neg_r_reg ? -rem_reg : rem_reg);
  assign div_result = rem_sel_reg ? r_fix : q_fix;

  // ---------------- outputs ----------------
  logic [XLEN-1:0] jalr_sum;

  assign jalr_sum    = op_a + imm_e;
  assign ex_stall    = stall_raw & ~reset;
  assign ex_valid    = valid_raw & ~reset;
  assign result_e    = (state_reg == S_DONE)  ? div_result :
                       (is_jal | is_jalr)     ? pc4_e      : alu_result;
  assign redirect    = valid_e & ex_valid & (is_jal | is_jalr | (is_branch & br_cond));
  assign redirect_pc = is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : pc_e + imm_e;

  logic lint_unused;
  assign lint_unused = ^{mul_p[PW-1:2*XLEN], instr_e[31:15], instr_e[11:0]};

endmodule

// File: tb/tb_ex_stage.sv
// Randomized self-checking bench for ex_stage against an arithmetic reference model,
// plus directed cases with hand-computed results.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        reset, valid_e, alu_src, is_branch, is_jal, is_jalr;
  logic [31:0] rd1_e, rd2_e, imm_e, pc4_e, instr_e, fwd_mem, fwd_wb;
  logic [4:0]  alu_op;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [31:0] result_e, store_data_e, redirect_pc;
  logic        redirect, ex_stall, ex_valid;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .reset(reset), .valid_e(valid_e), .rd1_e(rd1_e), .rd2_e(rd2_e),
    .imm_e(imm_e), .pc4_e(pc4_e), .instr_e(instr_e), .alu_op(alu_op), .alu_src(alu_src),
    .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .fwd_mem(fwd_mem), .fwd_wb(fwd_wb),
    .result_e(result_e), .store_data_e(store_data_e), .redirect(redirect),
    .redirect_pc(redirect_pc), .ex_stall(ex_stall), .ex_valid(ex_valid)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] r);
    if (sel == 2'b01) return fwd_mem;
    if (sel == 2'b10) return fwd_wb;
    return r;
  endfunction

  function automatic logic [31:0] alu_model(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic [4:0] sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    sh = b[4:0];
    case (op)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a << sh;
      5'd3:  return (sa < sb) ? 32'd1 : 32'd0;
      5'd4:  return (ua < ub) ? 32'd1 : 32'd0;
      5'd5:  return a ^ b;
      5'd6:  return a >> sh;
      5'd7:  return 32'($signed(a) >>> sh);
      5'd8:  return a | b;
      5'd9:  return a & b;
      5'd10: return b;
      5'd11: return pc4_e - 32'd4 + imm_e;
      5'd12: begin p = sa * sb; return p[31:0]; end
      5'd13: begin p = sa * sb; return p[63:32]; end
      5'd14: begin p = sa * ub; return p[63:32]; end
      5'd15: begin p = ua * ub; return p[63:32]; end
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] div_model(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    int sa, sb;
    bit ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      5'd16: if (b == 0) return 32'hFFFF_FFFF; else if (ovf) return a; else return sa / sb;
      5'd17: if (b == 0) return 32'hFFFF_FFFF; else return a / b;
      5'd18: if (b == 0) return a; else if (ovf) return 32'd0; else return sa % sb;
      default: if (b == 0) return a; else return a % b;
    endcase
  endfunction

  function automatic bit branch_model(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
    case (f3)
      3'b000: return a == b;
      3'b001: return a != b;
      3'b100: return $signed(a) < $signed(b);
      3'b101: return $signed(a) >= $signed(b);
      3'b110: return a < b;
      3'b111: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // Per-cycle comparison for non-divide cycles.
  task automatic step_check();
    logic [31:0] a, b2, b, exp_res, exp_pc;
    bit exp_redir;
    a       = fwd(fwd_a_sel, rd1_e);
    b2      = fwd(fwd_b_sel, rd2_e);
    b       = alu_src ? imm_e : b2;
    exp_res = (is_jal || is_jalr) ? pc4_e : alu_model(alu_op, a, b);
    exp_redir = valid_e && (is_jal || is_jalr ||
                (is_branch && branch_model(instr_e[14:12], a, b2)));
    exp_pc  = is_jalr ? ((a + imm_e) & 32'hFFFF_FFFE) : (pc4_e - 32'd4 + imm_e);
    chk1("stall", ex_stall, 1'b0);
    chk1("valid", ex_valid, valid_e);
    chk("store_data", store_data_e, b2);
    chk1("redirect", redirect, exp_redir);
    if (valid_e) chk("result", result_e, exp_res);
    if (exp_redir) chk("redirect_pc", redirect_pc, exp_pc);
  endtask

  // Runs a divide from the accept cycle through DONE; scrambles operand inputs while stalled.
  task automatic run_div(input int abort_at, output logic [31:0] res);
    logic [31:0] a, b, exp;
    int stalls, cycles;
    bit done;
    a      = fwd(fwd_a_sel, rd1_e);
    b      = alu_src ? imm_e : fwd(fwd_b_sel, rd2_e);
    exp    = div_model(alu_op, a, b);
    stalls = 0;
    cycles = 0;
    done   = 1'b0;
    res    = '0;
    while (!done && cycles < 40) begin
      @(negedge clk);
      cycles++;
      chk1("div_redirect", redirect, 1'b0);
      if (ex_stall) stalls++;
      if (ex_valid) begin
        done = 1'b1;
        res  = result_e;
        chk("div_result", result_e, exp);
        chk1("div_done_stall", ex_stall, 1'b0);
      end
      if (abort_at >= 0 && cycles == abort_at + 2) begin
        chk("abort_pre_stalls", stalls, abort_at + 2);
        reset   = 1'b1;
        valid_e = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk1("abort_stall", ex_stall, 1'b0);
        chk1("abort_valid", ex_valid, 1'b0);
        chk1("abort_redirect", redirect, 1'b0);
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
      if (!done) begin
        rd1_e   = $urandom;
        rd2_e   = $urandom;
        imm_e   = $urandom;
        fwd_mem = $urandom;
        fwd_wb  = $urandom;
      end
    end
    chk1("div_done_seen", done, 1'b1);
    chk("div_stall_cycles", stalls, 33);
    chk("div_occupancy", cycles, 34);
  endtask

  task automatic clear_inputs();
    valid_e = 1'b0; alu_src = 1'b0; is_branch = 1'b0; is_jal = 1'b0; is_jalr = 1'b0;
    rd1_e = '0; rd2_e = '0; imm_e = '0; pc4_e = 32'h4; instr_e = '0;
    fwd_mem = '0; fwd_wb = '0; alu_op = '0; fwd_a_sel = '0; fwd_b_sel = '0;
  endtask

  task automatic set_div(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    clear_inputs();
    valid_e = 1'b1;
    alu_op  = op;
    rd1_e   = a;
    rd2_e   = b;
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic drive_random();
    int kind;
    clear_inputs();
    valid_e   = ($urandom_range(0, 9) != 0);
    alu_op    = 5'($urandom_range(0, 31));
    alu_src   = 1'($urandom_range(0, 1));
    fwd_a_sel = 2'($urandom_range(0, 3));
    fwd_b_sel = 2'($urandom_range(0, 3));
    rd1_e     = rnd_val();
    rd2_e     = rnd_val();
    imm_e     = rnd_val();
    fwd_mem   = rnd_val();
    fwd_wb    = rnd_val();
    pc4_e     = $urandom & 32'hFFFF_FFFC;
    instr_e   = $urandom;
    kind      = $urandom_range(0, 5);
    if (kind < 3 && alu_op >= 5'd16 && alu_op <= 5'd19) alu_op = 5'd0;
    is_branch = (kind == 0);
    is_jal    = (kind == 1);
    is_jalr   = (kind == 2);
    if (alu_op == 5'd11) alu_src = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] res;
    int n_tx;

    // Reset with a divide presented: nothing may stall.
    set_div(5'd16, 32'd10, 32'd3);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("reset_stall", ex_stall, 1'b0);
    chk1("reset_valid", ex_valid, 1'b0);
    chk1("reset_redirect", redirect, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;

    // ADD with MEM forwarding on A.
    clear_inputs();
    valid_e = 1'b1; alu_op = 5'd0; fwd_a_sel = 2'b01; fwd_mem = 32'd5; rd2_e = 32'd7;
    @(negedge clk); step_check();
    chk("add_lit", result_e, 32'd12);
    chk1("add_valid_lit", ex_valid, 1'b1);
    chk1("add_stall_lit", ex_stall, 1'b0);
    @(posedge clk); #1;

    // BLT taken / BLTU not taken.
    clear_inputs();
    valid_e = 1'b1; is_branch = 1'b1; instr_e = 32'h0000_4000;
    rd1_e = 32'hFFFF_FFFF; rd2_e = 32'd1; pc4_e = 32'h104; imm_e = 32'h20;
    @(negedge clk); step_check();
    chk1("blt_redirect_lit", redirect, 1'b1);
    chk("blt_pc_lit", redirect_pc, 32'h120);
    @(posedge clk); #1;
    instr_e = 32'h0000_6000;
    @(negedge clk); step_check();
    chk1("bltu_redirect_lit", redirect, 1'b0);
    @(posedge clk); #1;

    // JALR clears bit 0 of the target.
    clear_inputs();
    valid_e = 1'b1; is_jalr = 1'b1; rd1_e = 32'h1001; imm_e = 32'd2; pc4_e = 32'h50;
    alu_src = 1'b1;
    @(negedge clk); step_check();
    chk("jalr_pc_lit", redirect_pc, 32'h1002);
    chk("jalr_result_lit", result_e, 32'h50);
    @(posedge clk); #1;

    // MULHU of all-ones operands.
    clear_inputs();
    valid_e = 1'b1; alu_op = 5'd15; rd1_e = 32'hFFFF_FFFF; rd2_e = 32'hFFFF_FFFF;
    @(negedge clk); step_check();
    chk("mulhu_lit", result_e, 32'hFFFF_FFFE);
    @(posedge clk); #1;

    // Directed divides, back to back.
    set_div(5'd16, 32'hFFFF_FFF9, 32'd2); run_div(-1, res); chk("div_m7_2_lit", res, 32'hFFFF_FFFD);
    set_div(5'd18, 32'hFFFF_FFF9, 32'd2); run_div(-1, res); chk("rem_m7_2_lit", res, 32'hFFFF_FFFF);
    set_div(5'd17, 32'd9, 32'd0);         run_div(-1, res); chk("divu_9_0_lit", res, 32'hFFFF_FFFF);
    set_div(5'd18, 32'd9, 32'd0);         run_div(-1, res); chk("rem_9_0_lit", res, 32'd9);
    set_div(5'd16, 32'h8000_0000, 32'hFFFF_FFFF); run_div(-1, res);
    chk("div_ovf_lit", res, 32'h8000_0000);

    // Reset during RUN count=10, then a full divide.
    set_div(5'd16, 32'd1000, 32'd3); run_div(10, res);
    set_div(5'd17, 32'd100, 32'd7);  run_div(-1, res); chk("divu_100_7_lit", res, 32'd14);

    // Randomized traffic.
    n_tx = 0;
    for (int i = 0; i < 300; i++) begin
      drive_random();
      if (valid_e && alu_op >= 5'd16 && alu_op <= 5'd19) begin
        run_div(-1, res);
      end else begin
        @(negedge clk); step_check();
        @(posedge clk); #1;
      end
      n_tx++;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
